// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared types and constants for the push-button bounce generator
package bounce_gen_pkg;

    // FSM states of the bounce generator
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Galois feedback taps for the 16-bit LFSR (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [15:0] LFSR_POLY    = 16'hB400;

    // Seed used when the configured seed is zero (an all-zero LFSR would lock up)
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR advancing every non-reset cycle
//
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset, loads seed
//   seed - reset value (caller guarantees non-zero)
//   q    - current LFSR state
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Right-shifting Galois form: the bit shifted out folds the taps back in
    always_comb begin
        q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_POLY) : (q_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/button_bounce_gen.sv
// rtl/button_bounce_gen.sv - emulated bouncy active-low push-button driven by press/release requests
//
// Parameters:
//   SEED          - LFSR reset value (0 replaced by 16'hACE1)
//   MIN_GAP       - minimum cycles between toggles (0 treated as 1)
//   GAP_MASK      - mask on the LFSR added to MIN_GAP per interval
//   K_MASK        - mask on LFSR[15:8] selecting bounce count k
//   SETTLE_CYCLES - stable cycles after the last toggle before done (0 treated as 1)
// Ports:
//   clk         - clock, all logic on posedge
//   rst         - synchronous active-high reset
//   press_req   - request a press (btn_n 1 -> 0)
//   release_req - request a release (btn_n 0 -> 1)
//   btn_n       - registered bouncy active-low button level
//   busy        - registered, high while a transition is in progress
//   done        - registered single-cycle pulse when a transition completes
// Build option:
//   BUTTON_BOUNCE_GEN_BOUNCE_EN - when defined, each transition makes 2*k+1 toggles;
//                                 otherwise a single clean toggle.
module button_bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED          = DEFAULT_SEED,
    parameter logic [15:0] MIN_GAP       = 16'd4,
    parameter logic [15:0] GAP_MASK      = 16'h000F,
    parameter logic [7:0]  K_MASK        = 8'h03,
    parameter logic [15:0] SETTLE_CYCLES = 16'd16
) (
    input  logic clk,
    input  logic rst,
    input  logic press_req,
    input  logic release_req,
    output logic btn_n,
    output logic busy,
    output logic done
);

    localparam logic [15:0] SEED_EFF    = (SEED == 16'd0) ? DEFAULT_SEED : SEED;
    localparam logic [16:0] MIN_GAP_EFF = (MIN_GAP == 16'd0) ? 17'd1 : {1'b0, MIN_GAP};
    localparam logic [15:0] SETTLE_EFF  = (SETTLE_CYCLES == 16'd0) ? 16'd1 : SETTLE_CYCLES;

    state_t      state_q, state_d;
    logic [16:0] gap_q, gap_d;
    logic [8:0]  tog_q, tog_d;
    logic [15:0] settle_q, settle_d;
    logic        btn_n_q, btn_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] lfsr_q;
    logic [16:0] interval;
    logic [8:0]  toggles_init;
    logic        accept;
    logic        toggle_now;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    // 17-bit sum so MIN_GAP + masked LFSR can never wrap
    assign interval = MIN_GAP_EFF + {1'b0, (lfsr_q & GAP_MASK)};

    // Odd toggle count 2*k+1 guarantees btn_n finishes at the requested level
`ifdef BUTTON_BOUNCE_GEN_BOUNCE_EN
    assign toggles_init = {(lfsr_q[15:8] & K_MASK), 1'b1};
`else
    // K_MASK has no effect here: k is forced to zero for a single clean edge
    assign toggles_init = {(lfsr_q[15:8] & K_MASK & 8'h00), 1'b1};
`endif

    // Only one request at a time, and only if it actually changes the level
    assign accept = (state_q == IDLE) && (press_req ^ release_req) &&
                    (press_req ? btn_n_q : ~btn_n_q);

    assign toggle_now = (state_q == BOUNCE) && (gap_q == 17'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            tog_q    <= '0;
            settle_q <= '0;
            btn_n_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            tog_q    <= tog_d;
            settle_q <= settle_d;
            btn_n_q  <= btn_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        tog_d    = tog_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BOUNCE;
                    gap_d   = interval;
                    tog_d   = toggles_init;
                end
            end
            BOUNCE: begin
                if (gap_q == 17'd1) begin
                    if (tog_q == 9'd1) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_EFF;
                        gap_d    = '0;
                        tog_d    = '0;
                    end else begin
                        tog_d = tog_q - 9'd1;
                        gap_d = interval;
                    end
                end else begin
                    gap_d = gap_q - 17'd1;
                end
            end
            SETTLE: begin
                if (settle_q == 16'd1) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered output next values
    always_comb begin
        btn_n_d = btn_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                end
            end
            BOUNCE: begin
                if (toggle_now) begin
                    btn_n_d = ~btn_n_q;
                end
            end
            SETTLE: begin
                if (settle_q == 16'd1) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign btn_n = btn_n_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// tb/tb_button_bounce_gen.sv - self-checking bench for button_bounce_gen
module tb_button_bounce_gen;

    localparam int NTAB = 40000;
    localparam int MIN_EFF [2] = '{4, 1};
    localparam int GMASK   [2] = '{0, 15};
    localparam int SET_EFF [2] = '{10, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic press_req = 1'b0;
    logic release_req = 1'b0;
    logic btn_n0, busy0, done0;
    logic btn_n1, busy1, done1;

    always #5 clk = ~clk;

    button_bounce_gen #(
        .SEED(16'hACE1), .MIN_GAP(16'd4), .GAP_MASK(16'h0000),
        .K_MASK(8'h03), .SETTLE_CYCLES(16'd10)
    ) dut0 (
        .clk(clk), .rst(rst), .press_req(press_req), .release_req(release_req),
        .btn_n(btn_n0), .busy(busy0), .done(done0)
    );

    button_bounce_gen #(
        .SEED(16'h0000), .MIN_GAP(16'd0), .GAP_MASK(16'h000F),
        .K_MASK(8'h03), .SETTLE_CYCLES(16'd0)
    ) dut1 (
        .clk(clk), .rst(rst), .press_req(press_req), .release_req(release_req),
        .btn_n(btn_n1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: LFSR sequence as a table indexed by non-reset edge count,
    // each accepted request expands into an absolute schedule of toggle edges.
    logic [15:0] lt [NTAB];
    logic mb [2];
    logic mbusy [2];
    logic mdone [2];
    int   mk;
    int   sched [2][8];
    int   ns [2];
    int   si [2];
    int   dk [2];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int toggles_for(input logic [15:0] v);
`ifdef BUTTON_BOUNCE_GEN_BOUNCE_EN
        return 2 * int'((v >> 8) & 16'h0003) + 1;
`else
        return 1;
`endif
    endfunction

    initial begin
        lt[0] = 16'hACE1;
        for (int i = 1; i < NTAB; i++) lt[i] = lfsr_step(lt[i-1]);
        mk = 0;
        for (int d = 0; d < 2; d++) begin
            mb[d] = 1'b1; mbusy[d] = 1'b0; mdone[d] = 1'b0;
            ns[d] = 0; si[d] = 0; dk[d] = -1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mk = 0;
            for (int d = 0; d < 2; d++) begin
                mb[d] = 1'b1; mbusy[d] = 1'b0; mdone[d] = 1'b0;
                ns[d] = 0; si[d] = 0; dk[d] = -1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mdone[d] = 1'b0;
                if (mbusy[d]) begin
                    if (si[d] < ns[d] && sched[d][si[d]] == mk) begin
                        mb[d] = ~mb[d];
                        si[d]++;
                    end
                    if (dk[d] == mk) begin
                        mdone[d] = 1'b1;
                        mbusy[d] = 1'b0;
                    end
                end else if ((press_req ^ release_req) &&
                             ((press_req && mb[d]) || (release_req && !mb[d]))) begin
                    int t;
                    t = mk;
                    ns[d] = toggles_for(lt[mk]);
                    for (int i = 0; i < ns[d]; i++) begin
                        t = t + MIN_EFF[d] + int'(lt[t] & GMASK[d][15:0]);
                        sched[d][i] = t;
                    end
                    si[d] = 0;
                    dk[d] = t + SET_EFF[d];
                    mbusy[d] = 1'b1;
                end
            end
            mk++;
            if (mk + 200 >= NTAB) begin
                errors++;
                $display("FAIL model_table: edge count %0d exceeds table", mk);
                $fatal(1, "model table exhausted");
            end
        end
    end

    // Compare process plus done-pulse counters
    int done_cnt0 = 0;
    always @(negedge clk) begin
        chk("dut0_btn_n", btn_n0, mb[0]);
        chk("dut0_busy",  busy0,  mbusy[0]);
        chk("dut0_done",  done0,  mdone[0]);
        chk("dut1_btn_n", btn_n1, mb[1]);
        chk("dut1_busy",  busy1,  mbusy[1]);
        chk("dut1_done",  done1,  mdone[1]);
        if (done0 === 1'b1) done_cnt0++;
    end

    // Toggle counter and push-button debouncer watching dut0
    int   tog0 = 0;
    logic tprev = 1'b1;
    logic db_lvl = 1'b1;
    int   db_cnt = 0;
    int   downs = 0;
    int   ups = 0;
    always @(posedge clk) begin
        if (btn_n0 !== tprev) tog0++;
        tprev = btn_n0;
        if (rst) begin
            db_lvl = 1'b1;
            db_cnt = 0;
        end else if (btn_n0 !== db_lvl) begin
            db_cnt++;
            if (db_cnt >= 6) begin
                db_lvl = btn_n0;
                db_cnt = 0;
                if (btn_n0 == 1'b0) downs++;
                else ups++;
            end
        end else begin
            db_cnt = 0;
        end
    end

    // Press sampled on the first edge after reset; LFSR=ACE1 there gives k=0 in either build
    task automatic press_after_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        press_req = 1'b1;
        @(negedge clk);
        press_req = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk({tag, "_busy0"}, busy0,  (j < 14));
            chk({tag, "_btn0"},  btn_n0, (j < 4));
            chk({tag, "_done0"}, done0,  (j == 14));
            chk({tag, "_busy1"}, busy1,  (j < 3));
            chk({tag, "_btn1"},  btn_n1, (j < 2));
            chk({tag, "_done1"}, done1,  (j == 3));
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input bit noise);
        int n;
        n = 0;
        while (!(busy0 === 1'b0 && busy1 === 1'b0) && n < 3000) begin
            if (noise && busy0 && busy1 && ($urandom % 4 == 0)) begin
                press_req   = 1'($urandom % 2);
                release_req = 1'($urandom % 2);
            end else begin
                press_req   = 1'b0;
                release_req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        press_req   = 1'b0;
        release_req = 1'b0;
        if (n >= 3000) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic do_trans(input bit is_press);
        int t_snap, d_snap, u_snap, t;
        wait_idle(1'b0);
        repeat ($urandom % 4) @(negedge clk);
        if ($urandom % 4 == 0) begin
            press_req = 1'b1; release_req = 1'b1;
            @(negedge clk);
            press_req = 1'b0; release_req = 1'b0;
            chk("both_high_ignored", busy0, 1'b0);
        end
        t_snap = tog0; d_snap = downs; u_snap = ups;
        press_req   = is_press;
        release_req = !is_press;
        @(negedge clk);
        press_req = 1'b0; release_req = 1'b0;
        wait_idle(1'b1);
        @(negedge clk);
        t = tog0 - t_snap;
`ifdef BUTTON_BOUNCE_GEN_BOUNCE_EN
        chk("toggle_odd", t % 2, 1);
        chk("toggle_range", (t >= 1 && t <= 7), 1'b1);
`else
        chk("toggle_single", t, 1);
`endif
        chk("final_level", btn_n0, !is_press);
        chk("debounce_down", downs - d_snap, is_press ? 1 : 0);
        chk("debounce_up",   ups - u_snap,   is_press ? 0 : 1);
    endtask

    initial begin
        int n, c, dsnap;
        logic prev;

        // Reset held for three edges
        repeat (3) begin
            @(negedge clk);
            chk("rst_btn0", btn_n0, 1'b1);
            chk("rst_busy0", busy0, 1'b0);
            chk("rst_done0", done0, 1'b0);
            chk("rst_btn1", btn_n1, 1'b1);
        end
        press_after_reset("first");

        // Press while already pressed: ignored
        press_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("press_at_low_busy", busy0, 1'b0);
            chk("press_at_low_btn", btn_n0, 1'b0);
        end
        // Both requests together: ignored
        press_req = 1'b1; release_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("both_busy0", busy0, 1'b0);
            chk("both_busy1", busy1, 1'b0);
        end
        // Release accepted, then requests while busy are ignored
        press_req = 1'b0; release_req = 1'b1;
        @(negedge clk);
        dsnap = done_cnt0;
        for (int j = 0; j < 4; j++) begin
            press_req = (j >= 2); release_req = (j < 2);
            chk("req_while_busy", busy0, 1'b1);
            @(negedge clk);
        end
        press_req = 1'b0; release_req = 1'b0;
        wait_idle(1'b0);
        @(negedge clk);
        chk("busy_release_done_count", done_cnt0 - dsnap, 1);
        chk("busy_release_level", btn_n0, 1'b1);

        // Reset on the second toggle (or in settle for single-toggle builds)
        n = 0;
`ifdef BUTTON_BOUNCE_GEN_BOUNCE_EN
        while (((lt[mk] >> 8) & 16'h0003) == 16'h0 && n < 200) begin
            @(negedge clk);
            n++;
        end
`endif
        dsnap = done_cnt0;
        press_req = 1'b1;
        @(negedge clk);
        press_req = 1'b0;
        prev = btn_n0; c = 0; n = 0;
`ifdef BUTTON_BOUNCE_GEN_BOUNCE_EN
        while (c < 2 && n < 200) begin
`else
        while (c < 1 && n < 200) begin
`endif
            @(negedge clk);
            if (btn_n0 !== prev) c++;
            prev = btn_n0;
            n++;
        end
`ifndef BUTTON_BOUNCE_GEN_BOUNCE_EN
        repeat (2) @(negedge clk);
`endif
        chk("abort_reached_toggle", (n < 200), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_btn0", btn_n0, 1'b1);
        chk("abort_busy0", busy0, 1'b0);
        chk("abort_done0", done0, 1'b0);
        chk("abort_no_done", done_cnt0 - dsnap, 0);
        press_after_reset("repeat");

        // Randomized press/release pairs from a clean reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 50; p++) begin
            do_trans(1'b1);
            do_trans(1'b0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_bounce_gen.md
BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value (value 0 replaced by 16'hACE1).
REQ-002 The block SHALL have parameter MIN_GAP, default 16'd4, meaning the minimum cycles between output toggles (value 0 treated as 1).
REQ-003 The block SHALL have parameter GAP_MASK, default 16'h000F, meaning the mask on the LFSR added to MIN_GAP per interval.
REQ-004 The block SHALL have parameter K_MASK, default 8'h03, meaning the mask on LFSR[15:8] that selects the bounce count k.
REQ-005 The block SHALL have parameter SETTLE_CYCLES, default 16'd16, meaning the stable cycles after the last toggle before completion (0 treated as 1).
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all logic on its posedge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port press_req, input, 1 bit: request a press transition.
REQ-009 The block SHALL have port release_req, input, 1 bit: request a release transition.
REQ-010 The block SHALL have port btn_n, output, 1 bit: registered, bouncy, active-low emulated push-button level.
REQ-011 The block SHALL have port busy, output, 1 bit: registered; high while a transition is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: registered; single-cycle pulse when a transition completes.

Function
REQ-013 FSM states SHALL be IDLE, BOUNCE and SETTLE.
REQ-014 The LFSR SHALL be 16-bit Galois, polynomial 16'hB400, advancing every non-reset cycle.
REQ-015 In IDLE, press_req=1 with release_req=0 and btn_n=1 SHALL be accepted: target=0, busy=1 next cycle, go to BOUNCE.
REQ-016 In IDLE, release_req=1 with press_req=0 and btn_n=0 SHALL be accepted: target=1, busy=1 next cycle, go to BOUNCE.
REQ-017 Requests SHALL be ignored (no state, output or done change) when busy, when both requests are high together, or when btn_n already equals the target level.
REQ-018 On accept, toggles remaining SHALL load 2*(LFSR[15:8] & K_MASK)+1, so btn_n always ends at the target level.
REQ-019 Each interval SHALL be MIN_GAP + (LFSR & GAP_MASK) cycles, computed at 17 bits without overflow, sampled at accept and after each toggle.
REQ-020 btn_n SHALL toggle exactly one interval after the accept edge or after the previous toggle edge.
REQ-021 After the last toggle, the FSM SHALL enter SETTLE, hold btn_n stable, count SETTLE_CYCLES, then pulse done=1 and drop busy=0 on the same edge and return to IDLE.
REQ-022 A request arriving on the same edge that done is asserted SHALL be ignored; requests SHALL be honoured from the following cycle.

Reset
REQ-023 While rst=1 the block SHALL set btn_n=1, busy=0, done=0, state=IDLE, all counters to 0, and LFSR=SEED.
REQ-024 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the transition with no done pulse.

Configuration
REQ-025 Macro BUTTON_BOUNCE_GEN_BOUNCE_EN defined SHALL enable the behaviour of REQ-018, i.e. a random odd toggle count.
REQ-026 With BUTTON_BOUNCE_GEN_BOUNCE_EN undefined, the toggle count SHALL be fixed at 1, giving a clean edge after one interval; K_MASK is then unused.

Structure
REQ-027 Package bounce_gen_pkg SHALL hold the state enum, the LFSR polynomial constant 16'hB400 and the default SEED constant.
REQ-028 The LFSR SHALL be a sub-module lfsr16 with ports clk, rst, seed and q.

Verification
REQ-029 Bench SHALL drive rst=1 for 3 cycles → btn_n=1, busy=0, done=0 throughout and after release.
REQ-030 Bench SHALL, with macro off, MIN_GAP=4, GAP_MASK=0 and SETTLE_CYCLES=10, sample press_req at edge T → busy=1 from T, btn_n=0 from T+4, done=1 only at T+14, busy=0 from T+14.
REQ-031 Bench SHALL, with macro on, K_MASK=3 and GAP_MASK=0, run 50 press/release pairs → per transition an odd toggle count in 1..7, final level equal to target, and exactly one down/up pulse from the push-button debouncer fed by btn_n.
REQ-032 Bench SHALL pulse release_req while busy and apply press_req while btn_n=0 → no toggle, no done, busy unchanged.
REQ-033 Bench SHALL assert press_req and release_req in the same cycle in IDLE → ignored; busy stays 0.
REQ-034 Bench SHALL apply rst on the 2nd toggle of a bounce → btn_n=1 and busy=0 next edge, no done, and the LFSR sequence repeats from SEED.
